// File: rtl/cv32e40p_ft_status_unit_pkg.sv
// Shared definitions for the FT status unit: register map, CTRL bit
// positions, IRQ state encoding and a popcount helper.
package cv32e40p_pkg2_ft;

  // Word addresses of the register port
  localparam logic [2:0] FT_ADDR_CTRL       = 3'd0;
  localparam logic [2:0] FT_ADDR_DET_CNT    = 3'd1;
  localparam logic [2:0] FT_ADDR_COR_CNT    = 3'd2;
  localparam logic [2:0] FT_ADDR_STICKY_DET = 3'd3;
  localparam logic [2:0] FT_ADDR_BROKEN     = 3'd4;
  localparam logic [2:0] FT_ADDR_SET_BROKEN = 3'd5;
  localparam logic [2:0] FT_ADDR_THRESHOLD  = 3'd6;

  // CTRL bit positions; bits 0..2 are write-only strobes
  localparam int FT_CTRL_CLR_CNT    = 0;
  localparam int FT_CTRL_CLR_STICKY = 1;
  localparam int FT_CTRL_IRQ_ACK    = 2;
  localparam int FT_CTRL_IRQ_EN     = 3;

  // Width of a popcount result over up to 32 inputs
  localparam int FT_POP_W = 6;

  typedef enum logic {
    FT_IRQ_IDLE    = 1'b0,
    FT_IRQ_PENDING = 1'b1
  } ft_irq_state_e;

  // Number of set bits in a 32-bit vector
  function automatic logic [FT_POP_W-1:0] ft_popcount(input logic [31:0] v);
    logic [FT_POP_W-1:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) begin
      n = n + {{(FT_POP_W-1){1'b0}}, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/cv32e40p_ft_status_unit_sat_counter.sv
// Saturating up-counter. A clear in the same cycle as an increment loads the
// increment, so no event is lost; the sum never wraps past all-ones.
module cv32e40p_ft_sat_counter #(
  parameter int WIDTH = 16,
  parameter int INC_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic [INC_W-1:0] inc_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic [WIDTH-1:0] cnt_next_o
);

  // One extra bit so the overflow of base + inc is visible before clamping
  localparam int SUM_W = ((WIDTH > INC_W) ? WIDTH : INC_W) + 1;
  localparam logic [SUM_W-1:0] SAT_MAX = SUM_W'({WIDTH{1'b1}});

  logic [WIDTH-1:0] cnt_q;
  logic [SUM_W-1:0] base;
  logic [SUM_W-1:0] sum;

  // Next value: restart from zero on clear, then add and clamp
  always_comb begin
    base = clr_i ? '0 : SUM_W'(cnt_q);
    sum  = base + SUM_W'(inc_i);
    if (sum > SAT_MAX) begin
      cnt_next_o = {WIDTH{1'b1}};
    end else begin
      cnt_next_o = sum[WIDTH-1:0];
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_next_o;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/cv32e40p_ft_status_unit.sv
// FT status unit: collects error/health signals from every triplicated
// wrapper, keeps saturating counters and sticky flags, raises a level
// interrupt and lets software force wrappers broken through a register port.
//
// Register port: a request is granted combinationally (gnt_o = req_i while
// out of reset). Writes take effect on the accepting clock edge. Every
// accepted request gets exactly one rvalid_o pulse on the following cycle;
// rdata_o carries the read value (sampled at the accept edge) or 0 for writes.
module cv32e40p_ft_status_unit
  import cv32e40p_pkg2_ft::*;
#(
  parameter int N_BLOCKS    = 8,
  parameter int CNT_W       = 16,
  parameter int IRQ_THR_RST = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_BLOCKS-1:0]   err_detected_i,
  input  logic [N_BLOCKS-1:0]   err_corrected_i,
  input  logic [3*N_BLOCKS-1:0] is_broken_i,
  output logic [3*N_BLOCKS-1:0] set_broken_o,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [2:0]            addr_i,
  input  logic [31:0]           wdata_i,
  output logic                  gnt_o,
  output logic                  rvalid_o,
  output logic [31:0]           rdata_o,
  output logic                  irq_o
);

  localparam int NB3 = 3 * N_BLOCKS;

  logic                accept;
  logic                wr;
  logic                wr_ctrl;
  logic                clr_cnt;
  logic                clr_sticky;
  logic                irq_ack;
  logic                irq_en_q;
  logic                irq_en_eff;
  logic [FT_POP_W-1:0] det_pop;
  logic [FT_POP_W-1:0] cor_pop;
  logic [CNT_W-1:0]    det_cnt;
  logic [CNT_W-1:0]    cor_cnt;
  logic [CNT_W-1:0]    win_cnt;
  logic [CNT_W-1:0]    det_next;
  logic [CNT_W-1:0]    cor_next;
  logic [CNT_W-1:0]    win_next;
  logic [CNT_W-1:0]    thr_q;
  logic [NB3-1:0]      set_broken_q;
  logic [NB3-1:0]      broken_q;
  logic [N_BLOCKS-1:0] sticky_q;
  logic [N_BLOCKS-1:0] sticky_d;
  logic                thr_hit;
  logic                broken_rise;
  logic                trigger;
  logic [31:0]         rd_mux;
  logic                rvalid_q;
  logic [31:0]         rdata_q;
  ft_irq_state_e       irq_state_q;
  ft_irq_state_e       irq_state_d;
  logic                unused_sink;

  // Handshake and write strobes
  assign gnt_o      = req_i & rst_n;
  assign accept     = req_i & rst_n;
  assign wr         = accept & we_i;
  assign wr_ctrl    = wr & (addr_i == FT_ADDR_CTRL);
  assign clr_cnt    = wr_ctrl & wdata_i[FT_CTRL_CLR_CNT];
  assign clr_sticky = wr_ctrl & wdata_i[FT_CTRL_CLR_STICKY];
  assign irq_ack    = wr_ctrl & wdata_i[FT_CTRL_IRQ_ACK];
  // Enable as it will be after this edge, so a CTRL write acts immediately
  assign irq_en_eff = wr_ctrl ? wdata_i[FT_CTRL_IRQ_EN] : irq_en_q;

  assign det_pop = ft_popcount(32'(err_detected_i));
  assign cor_pop = ft_popcount(32'(err_corrected_i));

  cv32e40p_ft_sat_counter #(.WIDTH(CNT_W), .INC_W(FT_POP_W)) u_det_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (clr_cnt),
    .inc_i      (det_pop),
    .cnt_o      (det_cnt),
    .cnt_next_o (det_next)
  );

  cv32e40p_ft_sat_counter #(.WIDTH(CNT_W), .INC_W(FT_POP_W)) u_cor_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (clr_cnt),
    .inc_i      (cor_pop),
    .cnt_o      (cor_cnt),
    .cnt_next_o (cor_next)
  );

  // Detections since the last acknowledge
  cv32e40p_ft_sat_counter #(.WIDTH(CNT_W), .INC_W(FT_POP_W)) u_win_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (irq_ack),
    .inc_i      (det_pop),
    .cnt_o      (win_cnt),
    .cnt_next_o (win_next)
  );

  // Sticky flags: a same-cycle detection beats the clear
  always_comb begin
    sticky_d = clr_sticky ? '0 : sticky_q;
    sticky_d = sticky_d | err_detected_i;
  end

  // Trigger sees this cycle's detections through the window's next value
  assign thr_hit     = (thr_q != '0) && (win_next >= thr_q);
  assign broken_rise = |(is_broken_i & ~broken_q);
  assign trigger     = thr_hit | broken_rise;

  // IRQ next state: disable and acknowledge both return to idle
  always_comb begin
    irq_state_d = irq_state_q;
    if (!irq_en_eff) begin
      irq_state_d = FT_IRQ_IDLE;
    end else if (irq_ack) begin
      irq_state_d = FT_IRQ_IDLE;
    end else if ((irq_state_q == FT_IRQ_IDLE) && trigger) begin
      irq_state_d = FT_IRQ_PENDING;
    end
  end

  // IRQ state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_state_q <= FT_IRQ_IDLE;
    end else begin
      irq_state_q <= irq_state_d;
    end
  end

  assign irq_o = (irq_state_q == FT_IRQ_PENDING);

  // Read multiplexer over current register contents
  always_comb begin
    rd_mux = '0;
    case (addr_i)
      FT_ADDR_CTRL:       rd_mux[FT_CTRL_IRQ_EN] = irq_en_q;
      FT_ADDR_DET_CNT:    rd_mux = 32'(det_cnt);
      FT_ADDR_COR_CNT:    rd_mux = 32'(cor_cnt);
      FT_ADDR_STICKY_DET: rd_mux = 32'(sticky_q);
      FT_ADDR_BROKEN:     rd_mux = 32'(is_broken_i);
      FT_ADDR_SET_BROKEN: rd_mux = 32'(set_broken_q);
      FT_ADDR_THRESHOLD:  rd_mux = 32'(thr_q);
      default:            rd_mux = '0;
    endcase
  end

  // Software-visible registers, sticky flags and the broken-edge history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_en_q     <= 1'b0;
      thr_q        <= CNT_W'(IRQ_THR_RST);
      set_broken_q <= '0;
      sticky_q     <= '0;
      broken_q     <= '0;
    end else begin
      irq_en_q <= irq_en_eff;
      sticky_q <= sticky_d;
      broken_q <= is_broken_i;
      if (wr && (addr_i == FT_ADDR_THRESHOLD)) begin
        thr_q <= wdata_i[CNT_W-1:0];
      end
      if (wr && (addr_i == FT_ADDR_SET_BROKEN)) begin
        set_broken_q <= wdata_i[NB3-1:0];
      end
    end
  end

  // Response channel: one pulse after each accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= accept;
      rdata_q  <= (accept && !we_i) ? rd_mux : '0;
    end
  end

  assign rvalid_o     = rvalid_q;
  assign rdata_o      = rdata_q;
  assign set_broken_o = set_broken_q;

  // Upper write-data bits and the main counters' look-ahead are not needed
  assign unused_sink = ^{wdata_i, det_next, cor_next};

endmodule

// File: tb/tb_cv32e40p_ft_status_unit.sv
// Bench for the FT status unit. Two instances share all inputs: the default
// configuration and a 4-bit counter variant used for saturation checks.
module tb_cv32e40p_ft_status_unit;

  localparam int NB = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NB-1:0] err_det;
  logic [NB-1:0] err_cor;
  logic [23:0]   is_broken;
  logic          req;
  logic          we;
  logic [2:0]    addr;
  logic [31:0]   wdata;

  logic [23:0] set_broken_a, set_broken_b;
  logic        gnt_a, gnt_b, rvalid_a, rvalid_b, irq_a, irq_b;
  logic [31:0] rdata_a, rdata_b;

  int n_cmp = 0;
  int n_err = 0;

  // Clock
  always #5 clk = ~clk;

  cv32e40p_ft_status_unit #(.N_BLOCKS(NB), .CNT_W(16), .IRQ_THR_RST(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .err_detected_i(err_det), .err_corrected_i(err_cor),
    .is_broken_i(is_broken), .set_broken_o(set_broken_a), .req_i(req), .we_i(we),
    .addr_i(addr), .wdata_i(wdata), .gnt_o(gnt_a), .rvalid_o(rvalid_a),
    .rdata_o(rdata_a), .irq_o(irq_a)
  );

  cv32e40p_ft_status_unit #(.N_BLOCKS(NB), .CNT_W(4), .IRQ_THR_RST(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .err_detected_i(err_det), .err_corrected_i(err_cor),
    .is_broken_i(is_broken), .set_broken_o(set_broken_b), .req_i(req), .we_i(we),
    .addr_i(addr), .wdata_i(wdata), .gnt_o(gnt_b), .rvalid_o(rvalid_b),
    .rdata_o(rdata_b), .irq_o(irq_b)
  );

  // Reference model: unbounded event totals since the last clear, clamped
  // when compared; sticky flags as a plain OR-accumulator.
  int            m_det;
  int            m_cor;
  logic [NB-1:0] m_sticky;
  wire           m_ctrl_wr = req && we && (addr == 3'd0);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_det    <= 0;
      m_cor    <= 0;
      m_sticky <= '0;
    end else begin
      m_det    <= ((m_ctrl_wr && wdata[0]) ? 0 : m_det) + $countones(err_det);
      m_cor    <= ((m_ctrl_wr && wdata[0]) ? 0 : m_cor) + $countones(err_cor);
      m_sticky <= ((m_ctrl_wr && wdata[1]) ? '0 : m_sticky) | err_det;
    end
  end

  function automatic int cap(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  // Driver tasks
  logic        rv;
  logic [31:0] da, db;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_read(input logic [2:0] a);
    req  = 1'b1;
    we   = 1'b0;
    addr = a;
    @(posedge clk);
    #1;
    req  = 1'b0;
    addr = 3'd0;
    rv   = rvalid_a;
    da   = rdata_a;
    db   = rdata_b;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    req   = 1'b1;
    we    = 1'b1;
    addr  = a;
    wdata = d;
    @(posedge clk);
    #1;
    req   = 1'b0;
    we    = 1'b0;
    addr  = 3'd0;
    wdata = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req = 1'b1; we = 1'b0; addr = 3'd6; wdata = '0;
    err_det = '0; err_cor = '0; is_broken = '0;
    repeat (3) tick();
    n_cmp++; if (gnt_a !== 1'b0) begin n_err++; $display("FAIL reset_gnt got=%b exp=0", gnt_a); end
    n_cmp++; if ({rvalid_a, irq_a, rdata_a, set_broken_a} !== '0) begin
      n_err++; $display("FAIL reset_outputs rvalid=%b irq=%b rdata=%h set_broken=%h exp=all zero",
                        rvalid_a, irq_a, rdata_a, set_broken_a); end
    req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    bus_read(3'd6);
    n_cmp++; if (rv !== 1'b1 || da !== 32'd4) begin n_err++; $display("FAIL reset_thr rvalid=%b rdata=%0d exp rvalid=1 rdata=4", rv, da); end
    tick();
    n_cmp++; if (rvalid_a !== 1'b0) begin n_err++; $display("FAIL rvalid_one_cycle got=%b exp=0", rvalid_a); end
    bus_read(3'd1);
    n_cmp++; if (rv !== 1'b1 || da !== 32'd0) begin n_err++; $display("FAIL reset_det rvalid=%b rdata=%0d exp rvalid=1 rdata=0", rv, da); end
  endtask

  task automatic test_detect();
    err_det = 8'b0000_0101;
    tick();
    err_det = '0;
    bus_read(3'd1);
    n_cmp++; if (da !== 32'(cap(m_det, 65535)) || da !== 32'd2) begin n_err++; $display("FAIL det_cnt got=%0d exp=2", da); end
    bus_read(3'd3);
    n_cmp++; if (da !== 32'(m_sticky) || da !== 32'h05) begin n_err++; $display("FAIL sticky got=%h exp=05", da); end
  endtask

  task automatic test_saturate();
    bus_write(3'd0, 32'h1);
    err_det = 8'hFF;
    repeat (3) tick();
    err_det = '0;
    bus_read(3'd1);
    n_cmp++; if (da !== 32'(cap(m_det, 65535))) begin n_err++; $display("FAIL det_wide got=%0d exp=%0d", da, cap(m_det, 65535)); end
    n_cmp++; if (db !== 32'(cap(m_det, 15)) || db !== 32'd15) begin n_err++; $display("FAIL det_sat4 got=%0d exp=15", db); end
  endtask

  task automatic test_clr_same_cycle();
    err_det = 8'h03;
    bus_write(3'd0, 32'h1);
    err_det = '0;
    bus_read(3'd1);
    n_cmp++; if (da !== 32'(cap(m_det, 65535)) || da !== 32'd2) begin n_err++; $display("FAIL clr_same_cycle got=%0d exp=2", da); end
  endtask

  task automatic test_random();
    logic [15:0] thr;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 25; c++) begin
        err_det = NB'($urandom_range(0, 255));
        err_cor = NB'($urandom_range(0, 255));
        if (c == 12 && r == 1) bus_write(3'd0, 32'h2);
        else tick();
      end
      err_det = '0; err_cor = '0;
      bus_read(3'd1);
      n_cmp++; if (da !== 32'(cap(m_det, 65535))) begin n_err++; $display("FAIL rnd_det round=%0d got=%0d exp=%0d", r, da, cap(m_det, 65535)); end
      n_cmp++; if (db !== 32'(cap(m_det, 15))) begin n_err++; $display("FAIL rnd_det4 round=%0d got=%0d exp=%0d", r, db, cap(m_det, 15)); end
      bus_read(3'd2);
      n_cmp++; if (da !== 32'(cap(m_cor, 65535))) begin n_err++; $display("FAIL rnd_cor round=%0d got=%0d exp=%0d", r, da, cap(m_cor, 65535)); end
      bus_read(3'd3);
      n_cmp++; if (da !== 32'(m_sticky)) begin n_err++; $display("FAIL rnd_sticky round=%0d got=%h exp=%h", r, da, m_sticky); end
    end
    thr = 16'($urandom_range(1, 65535));
    bus_write(3'd6, {16'hABCD, thr});
    n_cmp++; if (rvalid_a !== 1'b1 || rdata_a !== 32'd0) begin n_err++; $display("FAIL write_resp rvalid=%b rdata=%h exp rvalid=1 rdata=0", rvalid_a, rdata_a); end
    bus_read(3'd6);
    n_cmp++; if (da !== {16'd0, thr}) begin n_err++; $display("FAIL thr_rw got=%h exp=%h", da, thr); end
    bus_write(3'd6, 32'd4);
    bus_write(3'd7, 32'hFFFF_FFFF);
    bus_read(3'd7);
    n_cmp++; if (da !== 32'd0) begin n_err++; $display("FAIL reserved got=%h exp=0", da); end
    bus_write(3'd0, 32'h7);
    bus_read(3'd0);
    n_cmp++; if (da !== 32'd0) begin n_err++; $display("FAIL ctrl_strobes got=%h exp=0", da); end
  endtask

  task automatic test_irq_threshold();
    bus_write(3'd0, 32'h0C);
    bus_read(3'd0);
    n_cmp++; if (da !== 32'h8 || irq_a !== 1'b0) begin n_err++; $display("FAIL irq_en_rd ctrl=%h irq=%b exp ctrl=8 irq=0", da, irq_a); end
    for (int i = 0; i < 4; i++) begin
      err_det = NB'(1 << $urandom_range(0, NB - 1));
      tick();
      err_det = '0;
      n_cmp++; if (irq_a !== (i == 3)) begin n_err++; $display("FAIL irq_thr det=%0d got=%b exp=%b", i + 1, irq_a, (i == 3)); end
    end
    tick();
    n_cmp++; if (irq_a !== 1'b1) begin n_err++; $display("FAIL irq_level got=%b exp=1", irq_a); end
    bus_write(3'd0, 32'h0C);
    n_cmp++; if (irq_a !== 1'b0) begin n_err++; $display("FAIL irq_ack got=%b exp=0", irq_a); end
    tick();
    n_cmp++; if (irq_a !== 1'b0) begin n_err++; $display("FAIL irq_ack_hold got=%b exp=0", irq_a); end
    // ACK while the condition still holds: re-enter one cycle later
    bus_write(3'd6, 32'd1);
    err_det = 8'h10;
    bus_write(3'd0, 32'h0C);
    err_det = '0;
    n_cmp++; if (irq_a !== 1'b0) begin n_err++; $display("FAIL reenter_ack got=%b exp=0", irq_a); end
    tick();
    n_cmp++; if (irq_a !== 1'b1) begin n_err++; $display("FAIL reenter got=%b exp=1", irq_a); end
    bus_write(3'd6, 32'd4);
    bus_write(3'd0, 32'h0C);
  endtask

  task automatic test_broken();
    tick();
    n_cmp++; if (irq_a !== 1'b0) begin n_err++; $display("FAIL brk_pre got=%b exp=0", irq_a); end
    is_broken = 24'h00_0020;
    tick();
    n_cmp++; if (irq_a !== 1'b1) begin n_err++; $display("FAIL brk_irq got=%b exp=1", irq_a); end
    bus_write(3'd5, 32'h0000_0007);
    n_cmp++; if (set_broken_a !== 24'h7) begin n_err++; $display("FAIL set_broken_o got=%h exp=000007", set_broken_a); end
    bus_read(3'd5);
    n_cmp++; if (da !== 32'h7) begin n_err++; $display("FAIL set_broken_rd got=%h exp=7", da); end
    bus_read(3'd4);
    n_cmp++; if (da !== 32'h20) begin n_err++; $display("FAIL broken_rd got=%h exp=20", da); end
    bus_write(3'd0, 32'h0);
    n_cmp++; if (irq_a !== 1'b0) begin n_err++; $display("FAIL irq_disable got=%b exp=0", irq_a); end
    tick();
    n_cmp++; if (irq_a !== 1'b0) begin n_err++; $display("FAIL irq_disable_hold got=%b exp=0", irq_a); end
  endtask

  task automatic test_reset_mid();
    req = 1'b1; we = 1'b0; addr = 3'd1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (gnt_a !== 1'b0) begin n_err++; $display("FAIL mid_gnt got=%b exp=0", gnt_a); end
    @(posedge clk);
    #1;
    n_cmp++; if (rvalid_a !== 1'b0 || set_broken_a !== '0) begin n_err++; $display("FAIL mid_rvalid rvalid=%b set_broken=%h exp 0/0", rvalid_a, set_broken_a); end
    req = 1'b0; addr = 3'd0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_cmp++; if (irq_a !== 1'b0) begin n_err++; $display("FAIL mid_irq got=%b exp=0", irq_a); end
    bus_read(3'd6);
    n_cmp++; if (da !== 32'd4) begin n_err++; $display("FAIL mid_thr got=%0d exp=4", da); end
    bus_read(3'd1);
    n_cmp++; if (da !== 32'd0 || da !== 32'(m_det)) begin n_err++; $display("FAIL mid_det got=%0d exp=0", da); end
    bus_read(3'd3);
    n_cmp++; if (da !== 32'd0) begin n_err++; $display("FAIL mid_sticky got=%h exp=0", da); end
    bus_read(3'd5);
    n_cmp++; if (da !== 32'd0) begin n_err++; $display("FAIL mid_set_broken got=%h exp=0", da); end
    bus_read(3'd0);
    n_cmp++; if (da !== 32'd0) begin n_err++; $display("FAIL mid_ctrl got=%h exp=0", da); end
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_detect();
    test_saturate();
    test_clr_same_cycle();
    test_random();
    test_irq_threshold();
    test_broken();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
